// File: rtl/store_narrower.sv
// Store-path narrowing unit: aligns a byte/halfword/word store into its lane and
// performs read-modify-write against a data RAM that has no byte enables.
module store_narrower #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic [31:0]       req_data,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-3:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [31:0]       mem_rdata,
   output logic              mem_wr_en,
   output logic [31:0]       mem_wdata
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WR   = 3'd2,
      RESP = 3'd3,
      ERR  = 3'd4
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  lane_q;
   logic [1:0]  size_q;
   logic [31:0] data_q;
   logic        accept;

   // Misaligned half/word and the reserved size are rejected without touching memory.
   function automatic logic req_bad(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         SZ_BYTE: req_bad = 1'b0;
         SZ_HALF: req_bad = lo[0];
         SZ_WORD: req_bad = (lo != 2'b00);
         default: req_bad = 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] merge_byte(input logic [31:0] old,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  b);
      merge_byte = old;
      case (lane)
         2'd0:    merge_byte[7:0]   = b;
         2'd1:    merge_byte[15:8]  = b;
         2'd2:    merge_byte[23:16] = b;
         default: merge_byte[31:24] = b;
      endcase
   endfunction

   function automatic logic [31:0] merge_half(input logic [31:0] old,
                                              input logic        upper,
                                              input logic [15:0] h);
      merge_half = old;
      if (upper) merge_half[31:16] = h;
      else       merge_half[15:0]  = h;
   endfunction

   assign accept = (state == IDLE) && req_valid;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // mem_addr is a visible output with a defined reset value, so it gets reset too.
   always_ff @(posedge clk) begin
      if (reset)       mem_addr <= '0;
      else if (accept) mem_addr <= req_addr[ADDR_W-1:2];
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         lane_q <= req_addr[1:0];
         size_q <= req_size;
         data_q <= req_data;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_bad(req_size, req_addr[1:0])) state_nxt = ERR;
               else if (req_size == SZ_WORD)         state_nxt = WR;
               else                                  state_nxt = RD;
            end
         end
         RD:      state_nxt = WR;
         WR:      state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decode from state; only mem_wdata also depends on mem_rdata during WR.
   always_comb begin
      req_ready = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
      mem_wdata = '0;
      case (state)
         IDLE: req_ready = 1'b1;
         RD:   mem_rd_en = 1'b1;
         WR: begin
            mem_wr_en = 1'b1;
            case (size_q)
               SZ_BYTE: mem_wdata = merge_byte(mem_rdata, lane_q, data_q[7:0]);
               SZ_HALF: mem_wdata = merge_half(mem_rdata, lane_q[1], data_q[15:0]);
               default: mem_wdata = data_q;
            endcase
         end
         RESP: done = 1'b1;
         ERR: begin
            done = 1'b1;
            err  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_store_narrower.sv
// Bench for store_narrower: a small word memory plus a byte-level reference
// model of what each store should leave in that memory.
module tb_store_narrower;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic [31:0] req_data;
   logic        done;
   logic        err;
   logic [29:0] mem_addr;
   logic        mem_rd_en;
   logic [31:0] mem_rdata;
   logic        mem_wr_en;
   logic [31:0] mem_wdata;

   logic        pre_en;
   logic [3:0]  pre_idx;
   logic [31:0] pre_val;
   logic [31:0] mem     [0:15];
   logic [31:0] ref_mem [0:15];

   int checks;
   int errors;

   store_narrower #(.ADDR_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_size  (req_size),
      .req_data  (req_data),
      .done      (done),
      .err       (err),
      .mem_addr  (mem_addr),
      .mem_rd_en (mem_rd_en),
      .mem_rdata (mem_rdata),
      .mem_wr_en (mem_wr_en),
      .mem_wdata (mem_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM: read data appears the cycle after the strobe.
   always @(posedge clk) begin
      if (pre_en)    mem[pre_idx] <= pre_val;
      if (mem_wr_en) mem[mem_addr[3:0]] <= mem_wdata;
      if (mem_rd_en) mem_rdata <= mem[mem_addr[3:0]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] a,
                                             input logic [1:0] sz, input logic [31:0] d);
      int sh;
      logic [31:0] mask;
      sh = 8 * int'(a[1:0]);
      if (sz == 2'd2) return d;
      mask = (sz == 2'd1) ? (32'h0000_FFFF << sh) : (32'h0000_00FF << sh);
      return (old & ~mask) | ((d << sh) & mask);
   endfunction

   function automatic logic ref_bad(input logic [31:0] a, input logic [1:0] sz);
      return (sz == 2'd3) || (sz == 2'd1 && a[0] != 1'b0) || (sz == 2'd2 && a[1:0] != 2'b00);
   endfunction

   task automatic preload(input logic [3:0] idx, input logic [31:0] val);
      pre_en = 1'b1; pre_idx = idx; pre_val = val;
      @(posedge clk); #1;
      pre_en = 1'b0;
      ref_mem[idx] = val;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!req_ready && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk("ready_before_req", 32'(req_ready), 32'd1);
   endtask

   task automatic store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
      logic [3:0]  w;
      logic [31:0] expw;
      w = a[5:2];
      expw = ref_store(ref_mem[w], a, sz, d);
      wait_ready();
      req_valid = 1'b1; req_addr = a; req_size = sz; req_data = d;
      @(posedge clk); #1;
      // keep a junk request asserted while busy; it must not be taken
      req_addr = 32'($urandom_range(0, 63)); req_size = 2'($urandom); req_data = $urandom;
      if (ref_bad(a, sz)) begin
         chk("err_done", 32'(done), 32'd1);
         chk("err_err", 32'(err), 32'd1);
         chk("err_nostrobe", 32'({mem_rd_en, mem_wr_en}), 32'd0);
      end else begin
         if (sz != 2'd2) begin
            chk("rd_en", 32'(mem_rd_en), 32'd1);
            chk("rd_addr", 32'(mem_addr), 32'(a[31:2]));
            chk("rd_nodone", 32'({done, mem_wr_en}), 32'd0);
            @(posedge clk); #1;
         end
         chk("wr_en", 32'({mem_wr_en, mem_rd_en}), 32'b10);
         chk("wr_addr", 32'(mem_addr), 32'(a[31:2]));
         chk("wr_data", mem_wdata, expw);
         chk("wr_nodone", 32'(done), 32'd0);
         @(posedge clk); #1;
         chk("resp_done_err", 32'({done, err}), 32'b10);
         chk("resp_nostrobe", 32'({mem_rd_en, mem_wr_en}), 32'd0);
         ref_mem[w] = expw;
      end
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("ready_after", 32'(req_ready), 32'd1);
      chk("idle_nodone", 32'(done), 32'd0);
      chk("mem_word", mem[w], ref_mem[w]);
   endtask

   initial begin
      logic [31:0] a;
      logic [1:0]  sz;
      checks = 0; errors = 0;
      reset = 1'b1; req_valid = 1'b1; req_addr = 32'h10; req_size = 2'd2; req_data = 32'h5;
      pre_en = 1'b0; pre_idx = '0; pre_val = '0;

      // reset held two cycles with a request present
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk("rst_ready", 32'(req_ready), 32'd1);
         chk("rst_done", 32'({done, err}), 32'd0);
         chk("rst_strobes", 32'({mem_rd_en, mem_wr_en}), 32'd0);
         chk("rst_addr", 32'(mem_addr), 32'd0);
         chk("rst_wdata", mem_wdata, 32'd0);
      end
      req_valid = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_idle", 32'({done, mem_rd_en, mem_wr_en}), 32'd0);

      for (int i = 0; i < 16; i++) preload(4'(i), $urandom);

      // directed examples
      store(32'h10, 2'd2, 32'h1234_5678);
      chk("sw_result", mem[4], 32'h1234_5678);
      preload(4'd4, 32'h1122_3344);
      store(32'h13, 2'd0, 32'hFFFF_FFAB);
      chk("sb_result", mem[4], 32'hAB22_3344);
      preload(4'd8, 32'hAAAA_BBBB);
      store(32'h22, 2'd1, 32'h0000_BEEF);
      chk("sh_hi_result", mem[8], 32'hBEEF_BBBB);
      preload(4'd8, 32'hAAAA_BBBB);
      store(32'h20, 2'd1, 32'h0000_BEEF);
      chk("sh_lo_result", mem[8], 32'hAAAA_BEEF);
      store(32'h21, 2'd1, 32'h1111_1111);
      store(32'h22, 2'd2, 32'h2222_2222);
      store(32'h24, 2'd3, 32'h3333_3333);
      store(32'h24, 2'd2, 32'hCAFE_F00D);
      chk("sw_after_err", mem[9], 32'hCAFE_F00D);

      // reset while in RD of a byte store: no write, no done
      wait_ready();
      req_valid = 1'b1; req_addr = 32'h15; req_size = 2'd0; req_data = 32'h77;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rstrd_rd", 32'(mem_rd_en), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rstrd_ready", 32'(req_ready), 32'd1);
      chk("rstrd_quiet", 32'({done, mem_rd_en, mem_wr_en}), 32'd0);
      @(posedge clk); #1;
      chk("rstrd_nowr", 32'({done, mem_wr_en}), 32'd0);
      chk("rstrd_mem", mem[5], ref_mem[5]);

      // reset while in WR of a word store: the write still lands
      req_valid = 1'b1; req_addr = 32'h18; req_size = 2'd2; req_data = 32'h0BAD_BEEF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rstwr_wr", 32'(mem_wr_en), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      ref_mem[6] = 32'h0BAD_BEEF;
      chk("rstwr_nodone", 32'(done), 32'd0);
      chk("rstwr_ready", 32'(req_ready), 32'd1);
      chk("rstwr_mem", mem[6], ref_mem[6]);

      // randomized stores against the reference memory
      for (int i = 0; i < 60; i++) begin
         a  = 32'($urandom_range(0, 63));
         sz = 2'($urandom_range(0, 3));
         store(a, sz, $urandom);
      end
      for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
